// File: rtl/scr1_dmem_router.sv
// scr1_dmem_router: steers core data requests to the TCM or the external bridge, tracks the single
// outstanding access and turns a hung external access into an ERROR response after a bounded wait.
package scr1_memif_pkg;
    localparam int SCR1_DMEM_AWIDTH = 32;
    localparam int SCR1_DMEM_DWIDTH = 32;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_router
    import scr1_memif_pkg::*;
#(
    parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT_TCM_ADDR_MASK    = 'hFFFF0000,
    parameter logic [SCR1_DMEM_AWIDTH-1:0] SCR1_PORT_TCM_ADDR_PATTERN = 'h00480000,
    parameter int unsigned                 SCR1_EXT_TIMEOUT           = 255
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic                        dmem_req,
    input  type_scr1_mem_cmd_e          dmem_cmd,
    input  type_scr1_mem_width_e        dmem_width,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
    output logic                        dmem_req_ack,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
    output type_scr1_mem_resp_e         dmem_resp,

    output logic                        tcm_req,
    output type_scr1_mem_cmd_e          tcm_cmd,
    output type_scr1_mem_width_e        tcm_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] tcm_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] tcm_wdata,
    input  logic                        tcm_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] tcm_rdata,
    input  type_scr1_mem_resp_e         tcm_resp,

    output logic                        ext_req,
    output type_scr1_mem_cmd_e          ext_cmd,
    output type_scr1_mem_width_e        ext_width,
    output logic [SCR1_DMEM_AWIDTH-1:0] ext_addr,
    output logic [SCR1_DMEM_DWIDTH-1:0] ext_wdata,
    input  logic                        ext_req_ack,
    input  logic [SCR1_DMEM_DWIDTH-1:0] ext_rdata,
    input  type_scr1_mem_resp_e         ext_resp
);

    localparam int CNT_W = (SCR1_EXT_TIMEOUT > 0) ? $clog2(SCR1_EXT_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCR1_EXT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = (SCR1_EXT_TIMEOUT > 0) ? CNT_W'(SCR1_EXT_TIMEOUT - 1) : '0;

    // IDLE: nothing outstanding | TCM/EXT: access outstanding on that port | DRAIN: timed out, late ext resp pending
    typedef enum logic [1:0] {ST_IDLE, ST_TCM, ST_EXT, ST_DRAIN} state_e;

    state_e           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             sel_tcm, done, can_issue, port_ack, timeout;

    assign sel_tcm   = ((dmem_addr & SCR1_PORT_TCM_ADDR_MASK) == SCR1_PORT_TCM_ADDR_PATTERN);

    assign tcm_cmd   = dmem_cmd;
    assign tcm_width = dmem_width;
    assign tcm_addr  = dmem_addr;
    assign tcm_wdata = dmem_wdata;
    assign ext_cmd   = dmem_cmd;
    assign ext_width = dmem_width;
    assign ext_addr  = dmem_addr;
    assign ext_wdata = dmem_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        done = ((state == ST_TCM) && (tcm_resp != SCR1_MEM_RESP_NOTRDY)) ||
               ((state == ST_EXT) && (ext_resp != SCR1_MEM_RESP_NOTRDY));
        // The counter reaches the limit at the end of this cycle; a real response in the same cycle wins.
        timeout = (SCR1_EXT_TIMEOUT > 0) && (state == ST_EXT) &&
                  (ext_resp == SCR1_MEM_RESP_NOTRDY) && (cnt == CNT_LAST);

        // Request outputs are held low while reset is asserted so nothing leaks out mid-reset.
        can_issue    = !rst && ((state == ST_IDLE) || done);
        port_ack     = sel_tcm ? tcm_req_ack : ext_req_ack;
        tcm_req      = dmem_req & can_issue & sel_tcm;
        ext_req      = dmem_req & can_issue & ~sel_tcm;
        dmem_req_ack = dmem_req & can_issue & port_ack;

        state_next = state;
        cnt_next   = cnt;
        if (dmem_req_ack) begin
            state_next = sel_tcm ? ST_TCM : ST_EXT;
            cnt_next   = '0;
        end else if (done) begin
            state_next = ST_IDLE;
        end else if (timeout) begin
            state_next = ST_DRAIN;
        end else if ((state == ST_DRAIN) && (ext_resp != SCR1_MEM_RESP_NOTRDY)) begin
            state_next = ST_IDLE;
        end

        if (!dmem_req_ack && (state == ST_EXT) && (ext_resp == SCR1_MEM_RESP_NOTRDY) && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end

        dmem_resp  = SCR1_MEM_RESP_NOTRDY;
        dmem_rdata = '0;
        case (state)
            ST_TCM: begin
                dmem_resp  = tcm_resp;
                dmem_rdata = tcm_rdata;
            end
            ST_EXT: begin
                if (timeout) begin
                    dmem_resp = SCR1_MEM_RESP_RDY_ER;
                end else begin
                    dmem_resp  = ext_resp;
                    dmem_rdata = ext_rdata;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
